mdio_slave: RTL and testbench
=============================

MDIO_SLAVE -- requirements
Module: mdio_slave

Interface
REQ-001 SHALL have parameter PREAMBLE_MIN, default 32, giving the consecutive 1 bits required before a start-of-frame (legal range 1..32).
REQ-002 SHALL have port gtx_clk, input, 1 bit: the single clock; all logic is on the rising edge; frequency >= 4x mdc.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port phy_addr, input, 5 bits: this responder's PHY address, treated as static.
REQ-005 SHALL have port mdc, input, 1 bit: management clock from the station, asynchronous to gtx_clk.
REQ-006 SHALL have port mdio_in, input, 1 bit: management data from the pad.
REQ-007 SHALL have port mdio_out, output, 1 bit: data driven to the pad.
REQ-008 SHALL have port mdio_tri, output, 1 bit: 1 = pad high-Z, 0 = drive mdio_out.
REQ-009 SHALL have port reg_addr, output, 5 bits: REGAD of the current frame.
REQ-010 SHALL have port reg_rd_en, output, 1 bit: one-cycle read strobe.
REQ-011 SHALL have port reg_rd_data, input, 16 bits: read data, valid the cycle after reg_rd_en.
REQ-012 SHALL have port reg_wr_en, output, 1 bit: one-cycle write strobe.
REQ-013 SHALL have port reg_wr_data, output, 16 bits: write data, valid while reg_wr_en is high.
REQ-014 SHALL have port frame_err, output, 1 bit: one-cycle pulse on a malformed frame.

Function
REQ-015 SHALL pass mdc and mdio_in through 2-flop synchronizers, and SHALL detect an mdc rising edge (rise) as synchronized mdc = 1 with its previous registered value = 0.
REQ-016 SHALL sample one bit per rise, taking the synchronized mdio_in value in the rise cycle, with fields MSB first.
REQ-017 SHALL implement FSM states PRE, ST, OP, ADDR, TA, DATA.
REQ-018 In PRE, a 1 bit SHALL increment a 6-bit count saturating at PREAMBLE_MIN; a 0 bit with count >= PREAMBLE_MIN SHALL be taken as the first ST bit (go to ST); a 0 bit with count < PREAMBLE_MIN SHALL clear the count and stay in PRE.
REQ-019 In ST, a 1 bit SHALL go to OP; a 0 bit SHALL pulse frame_err and go to PRE.
REQ-020 OP SHALL take 2 bits: 10 = read, 01 = write, then go to ADDR; 00 or 11 SHALL pulse frame_err and go to PRE.
REQ-021 ADDR SHALL take 10 bits (PHYAD[4:0] then REGAD[4:0]); the frame matches when PHYAD == phy_addr; reg_addr SHALL update after the 10th bit and hold until the next frame's ADDR completes.
REQ-022 On a matched read, reg_rd_en SHALL pulse in the cycle after the 10th-address-bit rise, and reg_rd_data SHALL be latched into a shift register on the next cycle.
REQ-023 Read drive sequence, with each output change made one gtx_clk cycle after a rise:
  - after the 10th-address-bit rise: mdio_tri stays 1 (TA bit 1 = Z);
  - after the next rise: drive 0 (TA bit 2);
  - after each of the next 16 rises: drive data bits 15..0;
  - after the following rise: mdio_tri = 1, go to PRE.
REQ-024 On a write, TA SHALL sample 2 bits; the second bit != 0 SHALL pulse frame_err and go to PRE with no write.
REQ-025 On a write, DATA SHALL then shift in 16 bits; after the 16th rise a matched write SHALL pulse reg_wr_en for exactly 1 cycle, with reg_wr_data and reg_addr valid, then go to PRE.
REQ-026 An unmatched frame SHALL be tracked to its end with no strobes and mdio_tri held at 1.
REQ-027 Every return to PRE SHALL clear the preamble count, so back-to-back frames each need PREAMBLE_MIN ones.
REQ-028 mdio_tri SHALL be 0 only during TA bit 2 and DATA of a matched read.
REQ-029 At most one of reg_rd_en, reg_wr_en and frame_err SHALL be high in any cycle.

Reset
REQ-030 When reset = 1, asynchronously: state = PRE, preamble count = 0, mdio_tri = 1, mdio_out = 0, reg_addr = 0, reg_wr_data = 0, reg_rd_en = 0, reg_wr_en = 0, frame_err = 0, synchronizers = 0.
REQ-031 Reset asserted mid-read SHALL release mdio_tri within the same cycle, with no further drive until a new full frame.
REQ-032 After reset is released, the block SHALL require a full preamble before accepting a frame.

Verification
REQ-033 Bench SHALL cover: phy_addr = 5'h03; 32 ones, 01 10 00011 00101, reg_rd_data = 16'hA5C3 -> reg_rd_en pulses once with reg_addr = 5, mdio shows Z, 0, then 1010010111000011 on 16 rises, then mdio_tri = 1.
REQ-034 Bench SHALL cover: 32 ones, 01 01 00011 01010 10 16'h1234 -> single reg_wr_en with reg_addr = 10, reg_wr_data = 16'h1234.
REQ-035 Bench SHALL cover: write frame with PHYAD 5'h04 -> no reg_wr_en, no frame_err, mdio_tri held 1 throughout.
REQ-036 Bench SHALL cover: 31 ones then 01 10 ... -> frame ignored (count cleared), no strobes; a following correct frame is accepted.
REQ-037 Bench SHALL cover: OP = 11 -> frame_err pulses once, no strobes; write with TA = 11 -> frame_err pulses, no reg_wr_en.
REQ-038 Bench SHALL cover: reset asserted during read data bit 8 -> mdio_tri = 1 in the same cycle; a subsequent full read completes correctly.

Source files
------------

// File: rtl/mdio_slave.sv
// MDIO management responder. mdc and mdio_in are oversampled in the gtx_clk
// domain, so every frame bit is handled on a detected mdc rising edge.
module mdio_slave #(
    parameter int PREAMBLE_MIN = 32
) (
    input  logic        gtx_clk,
    input  logic        reset,
    input  logic [4:0]  phy_addr,
    input  logic        mdc,
    input  logic        mdio_in,
    output logic        mdio_out,
    output logic        mdio_tri,
    output logic [4:0]  reg_addr,
    output logic        reg_rd_en,
    input  logic [15:0] reg_rd_data,
    output logic        reg_wr_en,
    output logic [15:0] reg_wr_data,
    output logic        frame_err,
    output logic [2:0]  dbg_state
);
    typedef enum logic [2:0] {
        PRE  = 3'd0,
        ST   = 3'd1,
        OP   = 3'd2,
        ADDR = 3'd3,
        TA   = 3'd4,
        DATA = 3'd5
    } state_t;

    localparam logic [5:0] PRE_MIN = 6'(PREAMBLE_MIN);

    logic        mdc_s1_q, mdc_s2_q, mdc_prev_q;
    logic        mdio_s1_q, mdio_s2_q;
    logic        rise, bit_in;

    state_t      state_q, state_d;
    logic [5:0]  pre_cnt_q, pre_cnt_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic        op_b0_q, op_b0_d;
    logic        is_rd_q, is_rd_d;
    logic        match_q, match_d;
    logic [9:0]  addr_sr_q, addr_sr_d;
    logic [15:0] data_sr_q, data_sr_d;
    logic        rd_load_q, rd_load_d;
    logic        mdio_out_q, mdio_out_d;
    logic        mdio_tri_q, mdio_tri_d;
    logic [4:0]  reg_addr_q, reg_addr_d;
    logic [15:0] reg_wr_data_q, reg_wr_data_d;
    logic        reg_rd_en_q, reg_rd_en_d;
    logic        reg_wr_en_q, reg_wr_en_d;
    logic        frame_err_q, frame_err_d;
    logic [9:0]  addr_full;
    logic [15:0] data_full;

    assign rise      = mdc_s2_q & ~mdc_prev_q;
    assign bit_in    = mdio_s2_q;
    assign addr_full = {addr_sr_q[8:0], bit_in};
    assign data_full = {data_sr_q[14:0], bit_in};

    // Strobes reg_rd_en, reg_wr_en and frame_err are single-cycle pulses with no
    // back-pressure; reg_rd_data is captured the cycle after reg_rd_en.
    always_comb begin
        state_d       = state_q;
        pre_cnt_d     = (state_q == PRE) ? pre_cnt_q : 6'd0;
        bit_cnt_d     = bit_cnt_q;
        op_b0_d       = op_b0_q;
        is_rd_d       = is_rd_q;
        match_d       = match_q;
        addr_sr_d     = addr_sr_q;
        data_sr_d     = rd_load_q ? reg_rd_data : data_sr_q;
        rd_load_d     = reg_rd_en_q;
        mdio_out_d    = mdio_out_q;
        mdio_tri_d    = mdio_tri_q;
        reg_addr_d    = reg_addr_q;
        reg_wr_data_d = reg_wr_data_q;
        reg_rd_en_d   = 1'b0;
        reg_wr_en_d   = 1'b0;
        frame_err_d   = 1'b0;

        if (rise) begin
            case (state_q)
                PRE: begin
                    if (bit_in) begin
                        if (pre_cnt_q < PRE_MIN) pre_cnt_d = pre_cnt_q + 6'd1;
                    end else if (pre_cnt_q >= PRE_MIN) begin
                        state_d = ST;
                    end else begin
                        pre_cnt_d = 6'd0;
                    end
                end
                ST: begin
                    bit_cnt_d = 4'd0;
                    if (bit_in) begin
                        state_d = OP;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = PRE;
                    end
                end
                OP: begin
                    if (bit_cnt_q == 4'd0) begin
                        op_b0_d   = bit_in;
                        bit_cnt_d = 4'd1;
                    end else if (op_b0_q != bit_in) begin
                        is_rd_d   = op_b0_q;
                        bit_cnt_d = 4'd0;
                        state_d   = ADDR;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = PRE;
                    end
                end
                ADDR: begin
                    addr_sr_d = addr_full;
                    if (bit_cnt_q == 4'd9) begin
                        reg_addr_d  = addr_full[4:0];
                        match_d     = (addr_full[9:5] == phy_addr);
                        reg_rd_en_d = is_rd_q && (addr_full[9:5] == phy_addr);
                        bit_cnt_d   = 4'd0;
                        state_d     = TA;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
                TA: begin
                    if (bit_cnt_q == 4'd0) begin
                        bit_cnt_d = 4'd1;
                        if (is_rd_q && match_q) begin
                            mdio_tri_d = 1'b0;
                            mdio_out_d = 1'b0;
                        end
                    end else begin
                        bit_cnt_d = 4'd0;
                        if (is_rd_q) begin
                            state_d = DATA;
                            if (match_q) begin
                                mdio_out_d = data_sr_q[15];
                                data_sr_d  = {data_sr_q[14:0], 1'b0};
                            end
                        end else if (bit_in) begin
                            frame_err_d = 1'b1;
                            state_d     = PRE;
                        end else begin
                            state_d = DATA;
                        end
                    end
                end
                DATA: begin
                    if (is_rd_q) begin
                        if (bit_cnt_q == 4'd15) begin
                            mdio_tri_d = 1'b1;
                            mdio_out_d = 1'b0;
                            state_d    = PRE;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                            if (match_q) begin
                                mdio_out_d = data_sr_q[15];
                                data_sr_d  = {data_sr_q[14:0], 1'b0};
                            end
                        end
                    end else begin
                        data_sr_d = data_full;
                        if (bit_cnt_q == 4'd15) begin
                            if (match_q) begin
                                reg_wr_en_d   = 1'b1;
                                reg_wr_data_d = data_full;
                            end
                            state_d = PRE;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end
                default: state_d = PRE;
            endcase
        end
    end

    always_ff @(posedge gtx_clk or posedge reset) begin
        if (reset) begin
            mdc_s1_q      <= 1'b0;
            mdc_s2_q      <= 1'b0;
            mdc_prev_q    <= 1'b0;
            mdio_s1_q     <= 1'b0;
            mdio_s2_q     <= 1'b0;
            state_q       <= PRE;
            pre_cnt_q     <= 6'd0;
            bit_cnt_q     <= 4'd0;
            op_b0_q       <= 1'b0;
            is_rd_q       <= 1'b0;
            match_q       <= 1'b0;
            addr_sr_q     <= 10'd0;
            data_sr_q     <= 16'd0;
            rd_load_q     <= 1'b0;
            mdio_out_q    <= 1'b0;
            mdio_tri_q    <= 1'b1;
            reg_addr_q    <= 5'd0;
            reg_wr_data_q <= 16'd0;
            reg_rd_en_q   <= 1'b0;
            reg_wr_en_q   <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            mdc_s1_q      <= mdc;
            mdc_s2_q      <= mdc_s1_q;
            mdc_prev_q    <= mdc_s2_q;
            mdio_s1_q     <= mdio_in;
            mdio_s2_q     <= mdio_s1_q;
            state_q       <= state_d;
            pre_cnt_q     <= pre_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            op_b0_q       <= op_b0_d;
            is_rd_q       <= is_rd_d;
            match_q       <= match_d;
            addr_sr_q     <= addr_sr_d;
            data_sr_q     <= data_sr_d;
            rd_load_q     <= rd_load_d;
            mdio_out_q    <= mdio_out_d;
            mdio_tri_q    <= mdio_tri_d;
            reg_addr_q    <= reg_addr_d;
            reg_wr_data_q <= reg_wr_data_d;
            reg_rd_en_q   <= reg_rd_en_d;
            reg_wr_en_q   <= reg_wr_en_d;
            frame_err_q   <= frame_err_d;
        end
    end

    assign mdio_out    = mdio_out_q;
    assign mdio_tri    = mdio_tri_q;
    assign reg_addr    = reg_addr_q;
    assign reg_wr_data = reg_wr_data_q;
    assign reg_rd_en   = reg_rd_en_q;
    assign reg_wr_en   = reg_wr_en_q;
    assign frame_err   = frame_err_q;
    assign dbg_state   = state_q;
endmodule

// File: tb/tb_mdio_slave.sv
// Directed bench for mdio_slave: a station model drives frames on mdc/mdio_in,
// strobes are collected by a monitor and matched against an expected-event queue.
module tb_mdio_slave;
    localparam int HALF = 6;

    logic        gtx_clk;
    logic        reset;
    logic [4:0]  phy_addr;
    logic        mdc;
    logic        mdio_in;
    logic        mdio_out;
    logic        mdio_tri;
    logic [4:0]  reg_addr;
    logic        reg_rd_en;
    logic [15:0] reg_rd_data;
    logic        reg_wr_en;
    logic [15:0] reg_wr_data;
    logic        frame_err;
    logic [2:0]  dbg_state;

    // event word: {kind, reg_addr, data}; kind 1 = read, 2 = write, 3 = frame error
    logic [22:0] exp_q[$];
    logic [22:0] obs_q[$];
    logic [1:0]  mdio_q[$];
    int          cmp_cnt = 0;
    int          err_cnt = 0;
    int          tri_low_cnt = 0;
    int          multi_cnt = 0;
    int          t0;

    mdio_slave #(.PREAMBLE_MIN(32)) dut (
        .gtx_clk     (gtx_clk),
        .reset       (reset),
        .phy_addr    (phy_addr),
        .mdc         (mdc),
        .mdio_in     (mdio_in),
        .mdio_out    (mdio_out),
        .mdio_tri    (mdio_tri),
        .reg_addr    (reg_addr),
        .reg_rd_en   (reg_rd_en),
        .reg_rd_data (reg_rd_data),
        .reg_wr_en   (reg_wr_en),
        .reg_wr_data (reg_wr_data),
        .frame_err   (frame_err),
        .dbg_state   (dbg_state)
    );

    initial gtx_clk = 1'b0;
    always #5 gtx_clk = ~gtx_clk;

    always @(negedge gtx_clk) begin
        if (mdio_tri !== 1'b1) tri_low_cnt <= tri_low_cnt + 1;
        if ((32'(reg_rd_en) + 32'(reg_wr_en) + 32'(frame_err)) > 1) multi_cnt <= multi_cnt + 1;
        if (reg_rd_en === 1'b1)      obs_q.push_back({2'd1, reg_addr, 16'h0000});
        else if (reg_wr_en === 1'b1) obs_q.push_back({2'd2, reg_addr, reg_wr_data});
        else if (frame_err === 1'b1) obs_q.push_back({2'd3, 5'd0, 16'h0000});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        mdio_in = b;
        repeat (HALF) @(negedge gtx_clk);
        mdc = 1'b1;
        repeat (HALF) @(negedge gtx_clk);
        mdc = 1'b0;
    endtask

    task automatic send_head(input int npre, input logic [1:0] op, input logic [4:0] phy,
                             input logic [4:0] ra);
        for (int i = 0; i < npre; i++) send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(op[1]);
        send_bit(op[0]);
        for (int i = 4; i >= 0; i--) send_bit(phy[i]);
        for (int i = 4; i >= 0; i--) send_bit(ra[i]);
    endtask

    task automatic send_frame(input int npre, input logic [1:0] op, input logic [4:0] phy,
                              input logic [4:0] ra, input logic [1:0] ta, input logic [15:0] d);
        send_head(npre, op, phy, ra);
        send_bit(ta[1]);
        send_bit(ta[0]);
        for (int i = 15; i >= 0; i--) send_bit(d[i]);
    endtask

    // Station-side read: samples {mdio_tri, mdio_out} just before each of the
    // 18 turnaround/data rises. rst_at >= 0 asserts reset after that sample.
    task automatic read_frame(input logic [4:0] phy, input logic [4:0] ra,
                              input logic [15:0] d, input int rst_at);
        logic       m;
        logic [1:0] e;
        logic [1:0] o;
        m = (phy == phy_addr);
        reg_rd_data = d;
        if (m) exp_q.push_back({2'd1, ra, 16'h0000});
        for (int k = 0; k < 18; k++) begin
            if (!m || k == 0) e = 2'b10;
            else if (k == 1)  e = 2'b00;
            else              e = {1'b0, d[17 - k]};
            mdio_q.push_back(e);
        end
        send_head(32, 2'b10, phy, ra);
        for (int k = 0; k < 18; k++) begin
            mdio_in = 1'b1;
            repeat (HALF) @(negedge gtx_clk);
            o = {mdio_tri, mdio_out};
            check($sformatf("rd_mdio_bit%0d", k), 32'(o), 32'(mdio_q.pop_front()));
            if (k == rst_at) begin
                #1 reset = 1'b1;
                #1 check("rst_tri_same_cycle", 32'(mdio_tri), 32'd1);
                check("rst_reg_addr", 32'(reg_addr), 32'd0);
                repeat (3) @(negedge gtx_clk);
                reset = 1'b0;
                mdio_q.delete();
                return;
            end
            mdc = 1'b1;
            repeat (HALF) @(negedge gtx_clk);
            mdc = 1'b0;
        end
        repeat (HALF) @(negedge gtx_clk);
        check("rd_release", 32'({mdio_tri, mdio_out}), 32'(2'b10));
    endtask

    task automatic drain(input string tag);
        logic [22:0] e;
        logic [22:0] o;
        repeat (4) @(negedge gtx_clk);
        check({tag, "_events"}, 32'(obs_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 || obs_q.size() > 0) begin
            e = '0;
            o = '0;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            if (obs_q.size() > 0) o = obs_q.pop_front();
            check(tag, 32'(o), 32'(e));
        end
        check({tag, "_idle"}, 32'(dbg_state), 32'd0);
    endtask

    initial begin
        reset       = 1'b1;
        mdc         = 1'b0;
        mdio_in     = 1'b1;
        reg_rd_data = 16'h0000;
        phy_addr    = 5'h03;
        repeat (3) @(negedge gtx_clk);
        check("rst_mdio_tri", 32'(mdio_tri), 32'd1);
        check("rst_mdio_out", 32'(mdio_out), 32'd0);
        check("rst_reg_addr", 32'(reg_addr), 32'd0);
        check("rst_wr_data", 32'(reg_wr_data), 32'd0);
        check("rst_strobes", 32'({reg_rd_en, reg_wr_en, frame_err}), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        reset = 1'b0;
        repeat (4) @(negedge gtx_clk);

        // matched read of register 5
        read_frame(5'h03, 5'd5, 16'hA5C3, -1);
        drain("read_a5c3");

        // matched write of register 10
        exp_q.push_back({2'd2, 5'd10, 16'h1234});
        send_frame(32, 2'b01, 5'h03, 5'd10, 2'b10, 16'h1234);
        drain("write_1234");
        check("wr_addr_hold", 32'(reg_addr), 32'd10);

        // write addressed to another PHY: silent, pad released throughout
        t0 = tri_low_cnt;
        send_frame(32, 2'b01, 5'h04, 5'd7, 2'b10, 16'hBEEF);
        drain("write_other_phy");
        check("other_phy_tri", 32'(tri_low_cnt - t0), 32'd0);
        check("other_phy_addr", 32'(reg_addr), 32'd7);

        // read addressed to another PHY: never drives
        t0 = tri_low_cnt;
        read_frame(5'h07, 5'd2, 16'hFFFF, -1);
        drain("read_other_phy");
        check("rd_other_tri", 32'(tri_low_cnt - t0), 32'd0);

        // short preamble is ignored, then a good frame is accepted
        send_frame(31, 2'b10, 5'h03, 5'd5, 2'b11, 16'hFFFF);
        drain("short_preamble");
        exp_q.push_back({2'd2, 5'd2, 16'h0F0F});
        send_frame(32, 2'b01, 5'h03, 5'd2, 2'b10, 16'h0F0F);
        drain("after_short");

        // illegal opcode
        exp_q.push_back({2'd3, 5'd0, 16'h0000});
        send_frame(32, 2'b11, 5'h03, 5'd5, 2'b10, 16'h1234);
        drain("op_11");

        // write with bad turnaround
        exp_q.push_back({2'd3, 5'd0, 16'h0000});
        send_frame(32, 2'b01, 5'h03, 5'd9, 2'b11, 16'h5555);
        drain("write_ta_11");

        // reset while driving read data bit 8, then a clean read
        read_frame(5'h03, 5'd12, 16'h3C96, 9);
        drain("read_reset");
        repeat (4) @(negedge gtx_clk);
        read_frame(5'h03, 5'd31, 16'h8001, -1);
        drain("read_after_reset");
        check("rd_after_rst_addr", 32'(reg_addr), 32'd31);

        check("one_strobe_per_cycle", 32'(multi_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end
endmodule
